// File: rtl/reorder_pkg.sv
// reorder_pkg: shared width helpers and FSM encoding for the reorder ID allocator.
package reorder_pkg;

    typedef enum logic {INIT, RUN} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int sel_width(input int num_queues);
        return clog2(num_queues);
    endfunction

    function automatic int id_width(input int depth);
        return clog2(depth);
    endfunction

endpackage

// File: rtl/reorder_id_freelist.sv
// reorder_id_freelist: circular FIFO of free IDs with push, pop and occupancy count.
module reorder_id_freelist #(
    parameter int DEPTH    = 64,
    parameter int ID_WIDTH = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [ID_WIDTH-1:0] push_data_i,
    input  logic                pop_i,
    output logic [ID_WIDTH-1:0] pop_data_o,
    output logic [ID_WIDTH:0]   count_o
);

    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [ID_WIDTH-1:0] wr_ptr, rd_ptr;

    assign pop_data_o = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            wr_ptr  <= push_i ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr  <= pop_i ? rd_ptr + 1'b1 : rd_ptr;
            count_o <= count_o + {{ID_WIDTH{1'b0}}, push_i} - {{ID_WIDTH{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/reorder_id_allocator.sv
// reorder_id_allocator: hands out reorder IDs from a free list and recycles retired ones.
// Define REORDER_ID_ALLOC_CHECK_EN to track allocated IDs and reject releases of free IDs.
module reorder_id_allocator
    import reorder_pkg::*;
#(
    parameter  int NUM_QUEUES = 4,
    parameter  int DEPTH      = 64,
    localparam int SEL_WIDTH  = sel_width(NUM_QUEUES),
    localparam int ID_WIDTH   = id_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    input  logic [SEL_WIDTH-1:0] req_sel_i,
    input  logic                 req_break_i,
    output logic                 req_ready_o,
    input  logic                 trace_end_i,
    output logic                 id_push_o,
    output logic [ID_WIDTH-1:0]  id_value_o,
    output logic                 trace_push_o,
    output logic [SEL_WIDTH-1:0] trace_sel_o,
    output logic                 trace_break_o,
    output logic                 trace_update_o,
    input  logic                 full_i,
    input  logic                 commit_valid_i,
    input  logic [ID_WIDTH-1:0]  commit_value_i,
    output logic                 commit_pull_o,
    output logic [ID_WIDTH:0]    free_count_o,
    output logic                 init_done_o,
    output logic                 err_double_free_o
);

    state_t              state, state_nx;
    logic [ID_WIDTH-1:0] init_cnt, pop_id, fl_data;
    logic                run, accept, rel_req, rel_bad, rel_wr, fl_push, open_trace;

    // rst_i gates the combinational handshakes so nothing leaks out during reset.
    assign run          = (state == RUN) && !rst_i;
    assign init_done_o  = run;
    assign req_ready_o  = run && (free_count_o != '0) && !full_i;
    assign accept       = req_valid_i && req_ready_o;
    assign rel_req      = run && commit_valid_i;
    assign fl_push      = (state == INIT) || rel_wr;
    assign fl_data      = (state == INIT) ? init_cnt : commit_value_i;

`ifdef REORDER_ID_ALLOC_CHECK_EN
    logic [DEPTH-1:0] allocated;
    assign rel_bad       = (free_count_o == (ID_WIDTH+1)'(DEPTH)) || !allocated[commit_value_i];
    assign commit_pull_o = rel_req && !rel_bad;
    assign rel_wr        = commit_pull_o;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            allocated <= '0;
        end else begin
            if (accept) allocated[pop_id] <= 1'b1;
            if (rel_wr) allocated[commit_value_i] <= 1'b0;
        end
    end
`else
    assign rel_bad       = free_count_o == (ID_WIDTH+1)'(DEPTH);
    assign commit_pull_o = rel_req;
    assign rel_wr        = rel_req && !rel_bad;
`endif

    always_comb begin
        state_nx = (state == INIT && init_cnt == ID_WIDTH'(DEPTH - 1)) ? RUN : state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= INIT;
            init_cnt          <= '0;
            id_push_o         <= 1'b0;
            trace_push_o      <= 1'b0;
            id_value_o        <= '0;
            trace_sel_o       <= '0;
            trace_break_o     <= 1'b0;
            trace_update_o    <= 1'b0;
            open_trace        <= 1'b0;
            err_double_free_o <= 1'b0;
        end else begin
            state             <= state_nx;
            init_cnt          <= (state == INIT) ? init_cnt + 1'b1 : init_cnt;
            id_push_o         <= accept;
            trace_push_o      <= accept;
            id_value_o        <= accept ? pop_id : id_value_o;
            trace_sel_o       <= accept ? req_sel_i : trace_sel_o;
            trace_break_o     <= accept ? req_break_i : trace_break_o;
            trace_update_o    <= trace_end_i && open_trace && !accept;
            open_trace        <= accept ? !req_break_i : (trace_end_i ? 1'b0 : open_trace);
            err_double_free_o <= err_double_free_o || (rel_req && rel_bad);
        end
    end

    reorder_id_freelist #(
        .DEPTH    (DEPTH),
        .ID_WIDTH (ID_WIDTH)
    ) u_freelist (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fl_push),
        .push_data_i (fl_data),
        .pop_i       (accept),
        .pop_data_o  (pop_id),
        .count_o     (free_count_o)
    );

endmodule

// File: tb/tb_reorder_id_allocator.sv
// tb_reorder_id_allocator: directed scoreboard bench for the allocator at DEPTH=4, NUM_QUEUES=4.
module tb_reorder_id_allocator;

    logic       clk_i = 1'b0;
    logic       rst_i, req_valid_i, req_break_i, trace_end_i, full_i, commit_valid_i;
    logic [1:0] req_sel_i, commit_value_i;
    logic       req_ready_o, id_push_o, trace_push_o, trace_break_o, trace_update_o;
    logic       commit_pull_o, init_done_o, err_double_free_o;
    logic [1:0] id_value_o, trace_sel_o;
    logic [2:0] free_count_o;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] sel;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pending_upd = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   n;

    reorder_id_allocator #(.NUM_QUEUES(4), .DEPTH(4)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_sel_i         (req_sel_i),
        .req_break_i       (req_break_i),
        .req_ready_o       (req_ready_o),
        .trace_end_i       (trace_end_i),
        .id_push_o         (id_push_o),
        .id_value_o        (id_value_o),
        .trace_push_o      (trace_push_o),
        .trace_sel_o       (trace_sel_o),
        .trace_break_o     (trace_break_o),
        .trace_update_o    (trace_update_o),
        .full_i            (full_i),
        .commit_valid_i    (commit_valid_i),
        .commit_value_i    (commit_value_i),
        .commit_pull_o     (commit_pull_o),
        .free_count_o      (free_count_o),
        .init_done_o       (init_done_o),
        .err_double_free_o (err_double_free_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [1:0] sel, input logic brk, input logic [1:0] id);
        req_valid_i = 1'b1;
        req_sel_i   = sel;
        req_break_i = brk;
        exp_q.push_back({id, sel, brk});
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done_o && cycles < 10) begin
            cyc();
            cycles++;
        end
    endtask

    // Monitor: every registered push or trace update is matched against the scoreboard.
    always @(negedge clk_i) begin
        if (trace_update_o) begin
            chk("trace_update_expected", int'(pending_upd > 0), 1);
            if (pending_upd > 0) pending_upd--;
        end
        if (id_push_o || trace_push_o) begin
            chk("push_pair", trace_push_o, id_push_o);
            if (exp_q.size() == 0) begin
                chk("unexpected_push", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("id_value", id_value_o, mon_e.id);
                chk("trace_sel", trace_sel_o, mon_e.sel);
                chk("trace_break", trace_break_o, mon_e.brk);
            end
        end
    end

    initial begin
        rst_i = 1'b1; req_valid_i = 0; req_sel_i = 0; req_break_i = 0; trace_end_i = 0;
        full_i = 0; commit_valid_i = 0; commit_value_i = 0;
        cyc(); cyc();
        chk("rst_free_count", free_count_o, 0);
        chk("rst_init_done", init_done_o, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_err", err_double_free_o, 0);
        rst_i = 1'b0;
        wait_init(n);
        chk("init_cycles", n, 4);
        chk("init_free_count", free_count_o, 4);
        chk("init_ready", req_ready_o, 1);
        full_i = 1'b1; #1;
        chk("full_blocks_ready", req_ready_o, 0);
        full_i = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            req(2'((i + 1) % 4), 1'b1, 2'(i));
            cyc();
            chk("burst_push", id_push_o, 1);
        end
        req_valid_i = 0; #1;
        chk("empty_ready", req_ready_o, 0);
        chk("empty_free_count", free_count_o, 0);
        commit_valid_i = 1; commit_value_i = 2; #1;
        chk("commit2_pull", commit_pull_o, 1);
        cyc();
        commit_valid_i = 0;
        chk("commit2_free_count", free_count_o, 1);
        chk("commit2_ready", req_ready_o, 1);
        req(2'd2, 1'b1, 2'd2);
        cyc();
        req_valid_i = 0;
        chk("reuse_free_count", free_count_o, 0);
        commit_valid_i = 1; commit_value_i = 1;
        cyc();
        chk("commit1_free_count", free_count_o, 1);
        req(2'd0, 1'b1, 2'd1);
        commit_value_i = 0; #1;
        chk("simul_pull", commit_pull_o, 1);
        chk("simul_ready", req_ready_o, 1);
        cyc();
        req_valid_i = 0; commit_valid_i = 0;
        chk("simul_free_count", free_count_o, 1);
        req(2'd3, 1'b0, 2'd0);
        cyc();
        req_valid_i = 0;
        trace_end_i = 1; pending_upd++;
        cyc();
        trace_end_i = 0;
        chk("trace_update_pulse", trace_update_o, 1);
        cyc();
        chk("trace_update_one_cycle", trace_update_o, 0);
        trace_end_i = 1;
        cyc();
        trace_end_i = 0;
        chk("trace_end_repeat", trace_update_o, 0);
        cyc();
        chk("trace_end_repeat_late", trace_update_o, 0);
        for (int v = 0; v < 4; v++) begin
            commit_valid_i = 1; commit_value_i = 2'(v); #1;
            chk("release_pull", commit_pull_o, 1);
            cyc();
        end
        chk("all_free_count", free_count_o, 4);
        commit_value_i = 3; #1;
`ifdef REORDER_ID_ALLOC_CHECK_EN
        chk("overflow_pull", commit_pull_o, 0);
`else
        chk("overflow_pull", commit_pull_o, 1);
`endif
        cyc();
        commit_valid_i = 0;
        chk("overflow_err", err_double_free_o, 1);
        chk("overflow_free_count", free_count_o, 4);
        req(2'd1, 1'b1, 2'd0);
        cyc();
        req(2'd2, 1'b1, 2'd1);
        cyc();
        rst_i = 1; #1;
        chk("rst_mid_ready", req_ready_o, 0);
        cyc();
        chk("rst_mid_id_push", id_push_o, 0);
        chk("rst_mid_trace_push", trace_push_o, 0);
        chk("rst_mid_free_count", free_count_o, 0);
        chk("rst_mid_init_done", init_done_o, 0);
        chk("rst_mid_err", err_double_free_o, 0);
        chk("rst_mid_pull", commit_pull_o, 0);
        rst_i = 0; req_valid_i = 0;
        wait_init(n);
        chk("reinit_cycles", n, 4);
        chk("reinit_free_count", free_count_o, 4);
        req(2'd3, 1'b1, 2'd0);
        cyc();
        req_valid_i = 0;
        chk("refill_free_count", free_count_o, 3);
`ifdef REORDER_ID_ALLOC_CHECK_EN
        commit_valid_i = 1; commit_value_i = 3; #1;
        chk("free_id_pull", commit_pull_o, 0);
        cyc();
        commit_valid_i = 0;
        chk("free_id_err", err_double_free_o, 1);
        chk("free_id_free_count", free_count_o, 3);
`endif
        cyc(); cyc(); cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("updates_drained", pending_upd, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
